// File: rtl/dma_xfer_ctrl.sv
// DMA transfer sequencer: CPU-programmed base/count/direction, issues one cache-line
// transfer at a time to the line engine, gated on host FIFO status.
module dma_xfer_ctrl #(
  parameter int CL_SIZE_WIDTH = 512,
  parameter int ADDR_WIDTH    = 32,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_wr_en,
  input  logic                  cfg_rd_en,
  input  logic [1:0]            cfg_addr,
  input  logic [31:0]           cfg_wr_data,
  output logic [31:0]           cfg_rd_data,
  input  logic                  empty,
  input  logic                  full,
  output logic                  line_start,
  output logic                  line_dir,
  output logic [ADDR_WIDTH-1:0] line_addr,
  input  logic                  line_done,
  output logic                  busy,
  output logic                  done,
  output logic                  irq
);

  localparam int LINE_BYTES = CL_SIZE_WIDTH / 8;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FIN} state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_base, r_cur_addr;
  logic [CNT_WIDTH-1:0]  r_count, r_remain;
  logic                  r_dir, r_irq, r_aborted, r_err, r_abort_pend;
  logic                  r_busy, r_line_start, r_done;
  logic [31:0]           r_rd_data;

  logic w_wr_base, w_wr_count, w_start, w_abort, w_clear;
  logic w_busy, w_ready, w_issue;

  assign w_wr_base  = cfg_wr_en && (cfg_addr == 2'd0);
  assign w_wr_count = cfg_wr_en && (cfg_addr == 2'd1);
  assign w_start    = cfg_wr_en && (cfg_addr == 2'd2) && cfg_wr_data[0];
  assign w_abort    = cfg_wr_en && (cfg_addr == 2'd2) && cfg_wr_data[2];
  assign w_clear    = cfg_wr_en && (cfg_addr == 2'd3) && cfg_wr_data[0];
  assign w_busy     = (r_state != S_IDLE);
  assign w_ready    = r_dir ? !full : !empty;
  // Abort wins over a ready FIFO so no new line starts once abort is requested.
  assign w_issue    = (r_state == S_ISSUE) && !w_abort && w_ready;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = (r_count != '0) ? S_ISSUE : S_FIN;
      S_ISSUE: begin
        if (w_abort)      w_state_nxt = S_FIN;
        else if (w_ready) w_state_nxt = S_WAIT;
      end
      S_WAIT:  begin
        if (line_done) begin
          if ((r_remain == CNT_WIDTH'(1)) || w_abort || r_abort_pend) w_state_nxt = S_FIN;
          else                                                        w_state_nxt = S_ISSUE;
        end
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_line_start <= 1'b0;
      r_done       <= 1'b0;
      r_abort_pend <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
      r_line_start <= w_issue;
      r_done       <= (r_state == S_FIN);
      if (r_state == S_FIN)                   r_abort_pend <= 1'b0;
      else if ((r_state == S_WAIT) && w_abort) r_abort_pend <= 1'b1;
    end
  end

  // Register file; base is forced line-aligned on write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_wr_base && !w_busy)
        r_base <= ADDR_WIDTH'(cfg_wr_data) & ~ADDR_WIDTH'(LINE_BYTES - 1);
      if (w_wr_count && !w_busy)
        r_count <= CNT_WIDTH'(cfg_wr_data);
      if ((w_wr_base || w_wr_count || w_start) && w_busy) r_err <= 1'b1;
      else if (w_clear)                                   r_err <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_addr <= '0;
      r_remain   <= '0;
      r_dir      <= 1'b0;
      r_aborted  <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && w_start) begin
        r_cur_addr <= r_base;
        r_remain   <= r_count;
        r_dir      <= cfg_wr_data[1];
      end else if ((r_state == S_WAIT) && line_done) begin
        r_remain   <= r_remain - CNT_WIDTH'(1);
        r_cur_addr <= r_cur_addr + ADDR_WIDTH'(LINE_BYTES);
      end

      if ((r_state == S_IDLE) && w_start)                                r_aborted <= 1'b0;
      else if (((r_state == S_ISSUE) || (r_state == S_WAIT)) && w_abort) r_aborted <= 1'b1;
      else if (w_clear)                                                  r_aborted <= 1'b0;

      if (r_state == S_FIN) r_irq <= 1'b1;
      else if (w_clear)     r_irq <= 1'b0;
    end
  end

  // Read data samples current register values, so a same-cycle write reads back the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (cfg_rd_en) begin
      unique case (cfg_addr)
        2'd0:    r_rd_data <= 32'(r_base);
        2'd1:    r_rd_data <= 32'(r_count);
        2'd2:    r_rd_data <= {27'd0, r_err, r_aborted, r_irq, r_dir, r_busy};
        default: r_rd_data <= 32'(r_remain);
      endcase
    end
  end

  assign cfg_rd_data = r_rd_data;
  assign line_start  = r_line_start;
  assign line_dir    = r_dir;
  assign line_addr   = r_cur_addr;
  assign busy        = r_busy;
  assign done        = r_done;
  assign irq         = r_irq;

endmodule
